// File: rtl/sum_slice_seq.sv
// Wide W=N*K adder sequenced over an external N-bit `sum` slice, LSB slice first; done pulses K+1 cycles after start is accepted.
// start is sampled only in IDLE and is dropped while busy. Define SUM_SLICE_SEQ_OVF_EN to add the signed-overflow output ovf.
module sum_slice_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*K-1:0] op_a,
  input  logic [N*K-1:0] op_b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] result,
  output logic           cout,
  output logic [N-1:0]   adder_a,
  output logic [N-1:0]   adder_b,
  output logic           adder_cin,
  input  logic [N-1:0]   adder_s,
  input  logic           adder_cout
`ifdef SUM_SLICE_SEQ_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
`ifdef SUM_SLICE_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic last_slice;
  assign last_slice = (idx_q == IW'(K - 1));

  // Slice mux uses constant part-selects so the index never needs a wide multiply.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state_q == S_RUN) begin
      adder_cin = carry_q;
      for (int i = 0; i < K; i++) begin
        if (idx_q == IW'(i)) begin
          adder_a = a_q[i*N +: N];
          adder_b = b_q[i*N +: N];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SUM_SLICE_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < K; i++) begin
          if (idx_q == IW'(i)) result_d[i*N +: N] = adder_s;
        end
        carry_d = adder_cout;
        if (last_slice) begin
          cout_d  = adder_cout;
`ifdef SUM_SLICE_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (adder_s[N-1] != a_q[W-1]);
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SUM_SLICE_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SUM_SLICE_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SUM_SLICE_SEQ_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sum_slice_seq.sv
// Directed bench for sum_slice_seq (N=4, K=4) with a behavioural 4-bit slice adder attached.
module tb_sum_slice_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, adder_cin, adder_cout;
  logic [15:0] result;
  logic [3:0]  adder_a, adder_b, adder_s;
`ifdef SUM_SLICE_SEQ_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the external 4-bit ripple adder.
  logic [4:0] slice_sum;
  assign slice_sum  = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);
  assign adder_s    = slice_sum[3:0];
  assign adder_cout = slice_sum[4];

  sum_slice_seq #(.N(4), .K(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_s    (adder_s),
    .adder_cout (adder_cout)
`ifdef SUM_SLICE_SEQ_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one addition and waits (bounded) for done; returns latency in cycles and adder_cin per RUN cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output int lat, output logic [3:0] cins);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = ci;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = -1;
    cins = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= 4) cins[n-1] = adder_cin;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int         lat;
  logic [3:0] cins;
  int         done_seen;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
    #1;
    chk("idle_adder_a", 32'(adder_a), 32'h0);
    chk("idle_adder_cin", 32'(adder_cin), 32'd0);

    // 0x8888 + 0x8888
    do_op(16'h8888, 16'h8888, 1'b0, lat, cins);
    chk("t1_latency", 32'(lat), 32'd5);
    chk("t1_result", 32'(result), 32'h1110);
    chk("t1_cout", 32'(cout), 32'd1);
    chk("t1_busy_in_done", 32'(busy), 32'd1);

    // Full ripple 0xFFFF + 0x0001
    do_op(16'hFFFF, 16'h0001, 1'b0, lat, cins);
    chk("t2_latency", 32'(lat), 32'd5);
    chk("t2_cin_seq", 32'(cins), 32'b1110);
    chk("t2_result", 32'(result), 32'h0000);
    chk("t2_cout", 32'(cout), 32'd1);

    // Carry-in used, then zero add with pulse-width check
    do_op(16'h1999, 16'h1999, 1'b1, lat, cins);
    chk("t3_result", 32'(result), 32'h3333);
    chk("t3_cout", 32'(cout), 32'd0);
    do_op(16'h0000, 16'h0000, 1'b0, lat, cins);
    chk("t3b_latency", 32'(lat), 32'd5);
    chk("t3b_result", 32'(result), 32'h0000);
    chk("t3b_cout", 32'(cout), 32'd0);
    @(negedge clk);
    chk("t3b_done_width", 32'(done), 32'd0);
    chk("t3b_busy_after", 32'(busy), 32'd0);

    // start held high through RUN with new operands
    @(negedge clk);
    start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
    @(posedge clk);
    #1 op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("t4_latency", 32'(lat), 32'd5);
    chk("t4_result", 32'(result), 32'h2345);
    chk("t4_cout", 32'(cout), 32'd0);
    @(negedge clk);
    chk("t4_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("t4b_latency", 32'(lat), 32'd5);
    chk("t4b_result", 32'(result), 32'hFFFF);
    chk("t4b_cout", 32'(cout), 32'd1);
    repeat (2) @(negedge clk);
    chk("t4b_hold", 32'(result), 32'hFFFF);

    // Reset in the 2nd RUN cycle aborts with no done
    @(negedge clk);
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_result", 32'(result), 32'h0);
    chk("t5_rst_cout", 32'(cout), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("t5_no_done", 32'(done_seen), 32'd0);
    do_op(16'h0003, 16'h0004, 1'b0, lat, cins);
    chk("t5_latency", 32'(lat), 32'd5);
    chk("t5_result", 32'(result), 32'h0007);
    chk("t5_cout", 32'(cout), 32'd0);

`ifdef SUM_SLICE_SEQ_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, cins);
    chk("ovf_a_result", 32'(result), 32'h8000);
    chk("ovf_a_ovf", 32'(ovf), 32'd1);
    chk("ovf_a_cout", 32'(cout), 32'd0);
    do_op(16'hFFFF, 16'h0001, 1'b0, lat, cins);
    chk("ovf_b_ovf", 32'(ovf), 32'd0);
    chk("ovf_b_cout", 32'(cout), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
